// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between pipeline control and the
// iterative multiply/divide unit.
//   start/op/a/b : request (op 00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   cancel       : abort the operation in flight (exception flush)
//   busy/done    : status; done is a one-cycle pulse with hi/lo/div_zero valid
//   hi/lo        : 64-bit result (product, or remainder/quotient)
interface muldiv_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, cancel,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start, op, a, b, cancel,
                  output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: 32-bit iterative MULT/MULTU/DIV/DIVU, one add/sub step per cycle.
// Fixed latency: PREP (1) + RUN (32) + FIX (1), then a one-cycle DONE pulse.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : muldiv_seq_if.slave (request, cancel, status, hi/lo result)
module muldiv_seq (
  input  logic          i_clk,
  input  logic          i_rst_n,
  muldiv_seq_if.slave   bus
);
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_op;
  logic [31:0] r_a, r_b;          // operands as captured (raw bits)
  logic [31:0] r_opa, r_opb;      // working magnitudes, shifted during RUN
  logic [63:0] r_acc;             // mul: product; div: {rem, quot}
  logic [4:0]  r_cnt;
  logic        r_neg_res, r_neg_rem;
  logic [31:0] r_hi, r_lo;
  logic        r_div_zero;
  logic        w_busy, w_done;

  // Signed ops work on magnitudes; 0x80000000 stays 0x80000000 as unsigned.
  wire         w_sgn   = r_op[0];
  wire         w_is_div = r_op[1];
  wire  [31:0] w_mag_a = (w_sgn && r_a[31]) ? (~r_a + 32'd1) : r_a;
  wire  [31:0] w_mag_b = (w_sgn && r_b[31]) ? (~r_b + 32'd1) : r_b;

  // Multiply step: conditional add into upper half with carry, then shift right.
  wire  [32:0] w_mul_sum = {1'b0, r_acc[63:32]} + (r_opb[0] ? {1'b0, r_opa} : 33'd0);
  wire  [63:0] w_mul_acc = {w_mul_sum, r_acc[31:1]};

  // Restoring divide step: dividend bits enter from r_opa MSB. rem < divisor
  // keeps the shifted remainder below 2^33, so the 33-bit sign is exact.
  wire  [32:0] w_rem_sh  = {r_acc[63:32], r_opa[31]};
  wire  [32:0] w_diff    = w_rem_sh - {1'b0, r_opb};
  wire         w_ge      = ~w_diff[32];
  wire  [63:0] w_div_acc = {(w_ge ? w_diff[31:0] : w_rem_sh[31:0]), r_acc[30:0], w_ge};

  // Sign fix-up, modulo 2^64 / 2^32.
  wire  [63:0] w_prod = r_neg_res ? (~r_acc + 64'd1) : r_acc;
  wire  [31:0] w_quot = r_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  wire  [31:0] w_rem  = r_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; cancel overrides everything
  always_comb begin
    w_next = r_state;
    if (bus.cancel) w_next = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:  if (bus.start) w_next = S_PREP;
        S_PREP:  w_next = S_RUN;
        S_RUN:   if (r_cnt == 5'd31) w_next = S_FIX;
        S_FIX:   w_next = S_DONE;
        S_DONE:  w_next = bus.start ? S_PREP : S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Status outputs decode straight from the state register
  always_comb begin
    w_busy = (r_state == S_PREP) || (r_state == S_RUN) || (r_state == S_FIX);
    w_done = (r_state == S_DONE);
  end

  // Datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op <= '0; r_a <= '0; r_b <= '0; r_opa <= '0; r_opb <= '0;
      r_acc <= '0; r_cnt <= '0; r_neg_res <= 1'b0; r_neg_rem <= 1'b0;
      r_hi <= '0; r_lo <= '0; r_div_zero <= 1'b0;
    end else if (!bus.cancel) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // div_zero is only meaningful alongside done
          r_div_zero <= 1'b0;
          if (bus.start) begin
            r_op <= bus.op;
            r_a  <= bus.a;
            r_b  <= bus.b;
          end
        end
        S_PREP: begin
          r_opa     <= w_mag_a;
          r_opb     <= w_mag_b;
          r_neg_res <= w_sgn & (r_a[31] ^ r_b[31]);
          r_neg_rem <= w_sgn & r_a[31];
          r_acc     <= '0;
          r_cnt     <= '0;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 5'd1;
          if (w_is_div) begin
            r_acc <= w_div_acc;
            r_opa <= {r_opa[30:0], 1'b0};
          end else begin
            r_acc <= w_mul_acc;
            r_opb <= {1'b0, r_opb[31:1]};
          end
        end
        S_FIX: begin
          if (w_is_div && (r_b == 32'd0)) begin
            r_hi       <= r_a;
            r_lo       <= 32'hFFFF_FFFF;
            r_div_zero <= 1'b1;
          end else if (w_is_div) begin
            r_hi       <= w_rem;
            r_lo       <= w_quot;
            r_div_zero <= 1'b0;
          end else begin
            r_hi       <= w_prod[63:32];
            r_lo       <= w_prod[31:0];
            r_div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multi-cycle multiply/divide sequencer for the MIPS31 CPU. It executes MULT, MULTU, DIV and DIVU with one 32-bit add/subtract step per cycle and writes the 64-bit result into its HI/LO registers. The main ALU stays single-cycle; the pipeline control stalls on `busy` and collects results on `done`. It also provides the `cancel` hook used by exception flush.

## Interface
- No parameters. Width is fixed at 32 bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE or DONE.
- `op`  in  2  operation select, captured with `start`:
  - 00 MULTU
  - 01 MULT
  - 10 DIVU
  - 11 DIV
- `a`  in  32  multiplicand or dividend; captured with `start`.
- `b`  in  32  multiplier or divisor; captured with `start`.
- `cancel`  in  1  abort the operation in flight; has priority over everything except reset.
- `busy`  out  1  high in PREP, RUN and FIX.
- `done`  out  1  one-cycle pulse; HI/LO are valid in that cycle.
- `div_zero`  out  1  valid with `done`; 1 when a divide had `b == 0`.
- `hi`  out  32  MULT: product[63:32]. DIV: remainder.
- `lo`  out  32  MULT: product[31:0]. DIV: quotient.

## Operation
- **States:** IDLE, PREP, RUN, FIX, DONE. Reset enters IDLE.
- **Reset values:** `busy=0`, `done=0`, `div_zero=0`, `hi=0`, `lo=0`, iteration counter = 0.
- **IDLE/DONE + `start`:**
  - latch `op`, `a`, `b`; go to PREP.
  - `start` in PREP, RUN or FIX is ignored; the latched operands do not change.
- **PREP (1 cycle):**
  - Signed ops (`op[0]=1`): take magnitudes |a| and |b|; record `neg_res = a[31]^b[31]` and `neg_rem = a[31]`.
  - Unsigned ops: use operands as-is; `neg_res = neg_rem = 0`.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
  - Clear the 64-bit accumulator and set the counter to 0.
- **RUN (32 cycles, counter 0..31):**
  - Multiply: shift-add, LSB-first. If the multiplier LSB is 1, add the multiplicand to the upper accumulator half with a 33-bit carry. Then shift the accumulator right by 1.
  - Divide: restoring. Shift {rem, quot} left by 1 and form `rem - divisor` in 33 bits. If the result is non-negative, rem takes the difference and the quotient LSB is 1; otherwise the quotient LSB is 0.
  - Leave RUN when the counter reaches 31.
- **FIX (1 cycle):**
  - Multiply: if `neg_res`, write the two's complement of the 64-bit product; result goes to {hi, lo}.
  - Divide: if `neg_res`, negate the quotient; if `neg_rem`, negate the remainder. All arithmetic is modulo 2^32.
  - Divide with `b == 0`: skip the result. Write `hi = a` (original, unsigned bits), `lo = 0xFFFFFFFF`, and set `div_zero=1`.
  - HI/LO update only here.
- **DONE (1 cycle):**
  - `done=1`; `div_zero` holds its FIX value.
  - Next state is PREP if `start`, else IDLE.
  - In IDLE, `div_zero` returns to 0.
- **`cancel`** in any state: next state is IDLE. No `done` pulse. `hi`, `lo` and `div_zero` keep their prior values.
- **`rst_n` low at any time:** all outputs take their reset values immediately, including mid-RUN.
- **Corner result:** DIV 0x80000000 / 0xFFFFFFFF gives `lo=0x80000000`, `hi=0`. This follows from the wrap-around rule.

## Timing
- `start` is accepted at edge N:
  - PREP in cycle N+1
  - RUN in N+2..N+33
  - FIX in N+34
  - DONE (`done=1`) in N+35
- Fixed latency of 35 cycles for every op, including divide by zero.
- `busy` rises in cycle N+1 and falls in the DONE cycle.
- Back-to-back: `start` in the DONE cycle puts the next op in PREP the following cycle, with no IDLE gap.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Unsigned multiply:** MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `hi=0xFFFFFFFE`, `lo=0x00000001`; `done` exactly 35 cycles after the `start` edge; `busy` high for 34 cycles.
- **Signed multiply:** MULT a=0xFFFFFFFD (-3), b=7 → `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB`. Then MULT 0x80000000 × 0x80000000 → `hi=0x40000000`, `lo=0`.
- **Signed/unsigned divide:**
  - DIV -7/2 → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
  - DIVU 7/2 → `lo=3`, `hi=1`.
  - DIV 0x80000000/0xFFFFFFFF → `lo=0x80000000`, `hi=0`.
- **Divide by zero:** DIVU a=5, b=0 → `div_zero=1` with `done`, `hi=5`, `lo=0xFFFFFFFF`, latency still 35.
- **Cancel and ignored start:**
  - MULTU 3×4 completes with `lo=12`.
  - Start DIVU 100/7. Pulse `start` with other operands during RUN: it is ignored.
  - Pulse `cancel` in RUN cycle 10 → IDLE next cycle, no `done`, `lo` still 12.
- **Reset and back-to-back:**
  - Assert `rst_n=0` mid-RUN → `busy`, `done`, `hi`, `lo` all 0 asynchronously.
  - Then issue MULTU 2×3 with `start` held in its DONE cycle for DIVU 9/4 → second `done` 35 cycles after the first, with `lo=2`, `hi=1`.
